// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Packs an instruction field tuple into a 32-bit word in one of the R, I, D,
//   B or CB layouts. Each word goes into a small output FIFO. The word at the
//   head of the FIFO is shown together with its byte address.
//
// Ports
//   clk, rstN          clock and asynchronous active-low reset
//   inValid / inReady  field tuple handshake
//   fmt                0=R 1=I 2=D 3=B 4=CB, 5-7 illegal
//                      fmt=7 with opcode=11'h7FF is the flush command
//   opcode, rd, rn, rm, shamt, imm
//                      right-justified instruction fields
//   outValid/outReady  encoded word handshake
//   instOut, instAddr  FIFO head word and its byte address
//   encErr             one-cycle pulse for a rejected tuple
//   wordCount          FIFO occupancy
//
// Optional feature
//   ENC_RANGE_CHECK_EN rejects oversize imm or opcode fields with encErr.
//                      When it is undefined, oversize fields are truncated.
// -----------------------------------------------------------------------------
module inst_encoder #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_START = 32'h0
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        inValid,
  output logic        inReady,
  input  logic [2:0]  fmt,
  input  logic [10:0] opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [5:0]  shamt,
  input  logic [25:0] imm,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] instOut,
  output logic [31:0] instAddr,
  output logic        encErr,
  output logic [4:0]  wordCount
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] FULL_CNT = 5'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [4:0]    count_nxt;
  logic [31:0]   addr;
  logic          err_pulse;

  logic          accept;
  logic          is_flush;
  logic          illegal;
  logic          range_err;
  logic          push;
  logic          pop;
  logic [31:0]   enc_word;

  function automatic logic [31:0] pack_word(
    input logic [2:0]  f,
    input logic [10:0] op,
    input logic [4:0]  r_d,
    input logic [4:0]  r_n,
    input logic [4:0]  r_m,
    input logic [5:0]  sh,
    input logic [25:0] im
  );
    case (f)
      3'd0:    pack_word = {op, r_m, sh, r_n, r_d};
      3'd1:    pack_word = {op[9:0], im[11:0], r_n, r_d};
      3'd2:    pack_word = {op, im[8:0], 2'b00, r_n, r_d};
      3'd3:    pack_word = {op[5:0], im};
      3'd4:    pack_word = {op[7:0], im[18:0], r_d};
      default: pack_word = 32'h0;
    endcase
  endfunction

`ifdef ENC_RANGE_CHECK_EN
  // Any nonzero bit above the field width is an error. This includes
  // sign-extension bits.
  function automatic logic range_bad(
    input logic [2:0]  f,
    input logic [10:0] op,
    input logic [25:0] im
  );
    case (f)
      3'd1:    range_bad = (|im[25:12]) | op[10];
      3'd2:    range_bad = |im[25:9];
      3'd3:    range_bad = |op[10:6];
      3'd4:    range_bad = (|im[25:19]) | (|op[10:8]);
      default: range_bad = 1'b0;
    endcase
  endfunction

  assign range_err = range_bad(fmt, opcode, imm);
`else
  assign range_err = 1'b0;
`endif

  assign outValid = (count != 5'd0);
  assign pop      = outValid & outReady;

  // A full FIFO can still take a word on an edge where the head leaves.
  // This lets a push and a pop share an edge while the FIFO is full.
  assign inReady  = rstN & (state != ST_FLUSH) & ((count != FULL_CNT) | pop);

  assign accept   = inValid & inReady;
  assign is_flush = (fmt == 3'd7) & (opcode == 11'h7FF);
  assign illegal  = (fmt > 3'd4);
  assign push     = accept & ~illegal & ~range_err;
  assign enc_word = pack_word(fmt, opcode, rd, rn, rm, shamt, imm);

  assign count_nxt = count + {4'd0, push} - {4'd0, pop};

  // Control: state, pointers, occupancy, address, error pulse
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= 5'd0;
      addr      <= PC_START;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= accept & ~is_flush & (illegal | range_err);
      if (accept && is_flush) begin
        // A flush wins over a pop on the same edge.
        state  <= ST_FLUSH;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= 5'd0;
        addr   <= PC_START;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          addr   <= addr + 32'd4;
        end
        count <= count_nxt;
        state <= (count_nxt == 5'd0) ? ST_IDLE : ST_RUN;
      end
    end
  end

  // Data: FIFO storage written on the accepting edge
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  assign instOut   = outValid ? mem[rd_ptr] : 32'h0;
  assign instAddr  = addr;
  assign encErr    = err_pulse;
  assign wordCount = count;

endmodule
